// File: rtl/bus_transfer_controller.sv
// Command-driven transfer controller for a 4-entry register bank: MOVE, LOAD and READ
// sequenced by a three-state Moore FSM with latched command fields.
module bus_transfer_controller #(
  parameter int DATA_W = 16
) (
  input  logic              bus_controller_clock,
  input  logic              bus_controller_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_src,
  input  logic [1:0]        cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              cmd_error,
  output logic              busy,
  output logic [7:0]        transfer_count,
  output logic [5:0]        register_addr,
  output logic [DATA_W-1:0] bus_register_input,
  output logic              bus_register_input_en,
  output logic              bus_register_out_en,
  input  logic [DATA_W-1:0] bus_register_output
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_SRC  = 2'd1,
    WRITE_DST = 2'd2
  } state_t;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        op_q;
  logic [1:0]        src_q;
  logic [1:0]        dst_q;
  logic [DATA_W-1:0] hold_data;
  logic              accept;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge bus_controller_clock or negedge bus_controller_reset_n) begin
    if (!bus_controller_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus outputs depend only on state and latched fields, never on live cmd inputs.
  always_comb begin
    state_nxt             = state;
    cmd_ready             = 1'b0;
    busy                  = 1'b1;
    register_addr         = '0;
    bus_register_input    = '0;
    bus_register_input_en = 1'b0;
    bus_register_out_en   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          case (cmd_op)
            OP_MOVE, OP_READ: state_nxt = READ_SRC;
            OP_LOAD:          state_nxt = WRITE_DST;
            default:          state_nxt = IDLE;
          endcase
        end
      end
      READ_SRC: begin
        register_addr       = {4'b0000, src_q};
        bus_register_out_en = 1'b1;
        state_nxt           = (op_q == OP_MOVE) ? WRITE_DST : IDLE;
      end
      WRITE_DST: begin
        register_addr         = {4'b0000, dst_q};
        bus_register_input    = hold_data;
        bus_register_input_en = 1'b1;
        state_nxt             = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge bus_controller_clock or negedge bus_controller_reset_n) begin
    if (!bus_controller_reset_n) begin
      op_q           <= OP_MOVE;
      src_q          <= '0;
      dst_q          <= '0;
      hold_data      <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      cmd_error      <= 1'b0;
      transfer_count <= '0;
    end else begin
      rd_valid  <= 1'b0;
      cmd_error <= 1'b0;
      if (accept) begin
        op_q  <= cmd_op;
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        if (cmd_op == OP_LOAD) hold_data <= cmd_imm;
        if (cmd_op == OP_RSVD) cmd_error <= 1'b1;
      end
      if (state == READ_SRC) begin
        hold_data <= bus_register_output;
        if (op_q == OP_READ) begin
          rd_data  <= bus_register_output;
          rd_valid <= 1'b1;
        end
      end
      // Count on the edge leaving the last state of each command.
      if ((state == WRITE_DST) || (state == READ_SRC && op_q == OP_READ)) begin
        transfer_count <= transfer_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Bench for bus_transfer_controller: register-bank peripheral, schedule-based reference
// model compared every cycle, plus directed literal checks and randomized traffic.
module tb_bus_transfer_controller;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_src;
  logic [1:0]  cmd_dst;
  logic [15:0] cmd_imm;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        cmd_error;
  logic        busy;
  logic [7:0]  transfer_count;
  logic [5:0]  register_addr;
  logic [15:0] bus_register_input;
  logic        bus_register_input_en;
  logic        bus_register_out_en;
  logic [15:0] bus_register_output;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  bus_transfer_controller dut (
    .bus_controller_clock  (clk),
    .bus_controller_reset_n(rst_n),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_src               (cmd_src),
    .cmd_dst               (cmd_dst),
    .cmd_imm               (cmd_imm),
    .rd_data               (rd_data),
    .rd_valid              (rd_valid),
    .cmd_error             (cmd_error),
    .busy                  (busy),
    .transfer_count        (transfer_count),
    .register_addr         (register_addr),
    .bus_register_input    (bus_register_input),
    .bus_register_input_en (bus_register_input_en),
    .bus_register_out_en   (bus_register_out_en),
    .bus_register_output   (bus_register_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank peripheral; undriven bus shows noise so mistimed sampling is visible.
  logic [15:0] bank [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] noise = 16'h0;
  always @(negedge clk) noise <= 16'($urandom);
  always @(posedge clk) if (bus_register_input_en) bank[register_addr[1:0]] <= bus_register_input;
  assign bus_register_output = bus_register_out_en ? bank[register_addr[1:0]] : noise;

  typedef struct {
    logic        busy, in_en, out_en, last, is_read, rd_valid, err;
    logic [5:0]  addr;
    logic [15:0] wdata, rdval, rd_data;
    logic [7:0]  count;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  exp_t        was_e;
  logic [15:0] m_bank [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [7:0]  m_count = 8'h0;
  logic [15:0] m_rd = 16'h0;
  logic        m_rdv, m_er;

  function automatic exp_t idle_e();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic exp_t bus_e(input logic rd, input logic [1:0] r, input logic [15:0] d,
                                 input logic lst, input logic isrd);
    exp_t e;
    e = '{default: '0};
    e.busy = 1'b1; e.out_en = rd; e.in_en = !rd; e.addr = {4'b0, r};
    e.wdata = rd ? 16'h0 : d; e.rdval = d; e.last = lst; e.is_read = isrd;
    return e;
  endfunction

  // Reference model: each accepted command expands into a schedule of bus cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_count = 8'h0; m_rd = 16'h0; cur = idle_e();
    end else begin
      was_e = cur; m_rdv = 1'b0; m_er = 1'b0;
      if (was_e.busy && was_e.last) begin
        m_count = m_count + 8'd1;
        if (was_e.is_read) begin m_rd = was_e.rdval; m_rdv = 1'b1; end
        if (was_e.in_en) m_bank[was_e.addr[1:0]] = was_e.wdata;
      end
      if (q.size() == 0 && !was_e.busy && cmd_valid) begin
        case (cmd_op)
          2'b00: begin
            q.push_back(bus_e(1'b1, cmd_src, m_bank[cmd_src], 1'b0, 1'b0));
            q.push_back(bus_e(1'b0, cmd_dst, m_bank[cmd_src], 1'b1, 1'b0));
          end
          2'b01: q.push_back(bus_e(1'b0, cmd_dst, cmd_imm, 1'b1, 1'b0));
          2'b10: q.push_back(bus_e(1'b1, cmd_src, m_bank[cmd_src], 1'b1, 1'b1));
          default: m_er = 1'b1;
        endcase
      end
      if (q.size() != 0) cur = q.pop_front(); else cur = idle_e();
      cur.count = m_count; cur.rd_data = m_rd; cur.rd_valid = m_rdv; cur.err = m_er;
    end
  end

  logic [51:0] act_v, exp_v;
  always @(negedge clk) begin
    if (cmp_en) begin
      act_v = {busy, cmd_ready, register_addr, bus_register_input, bus_register_input_en,
               bus_register_out_en, rd_valid, rd_data, cmd_error, transfer_count};
      exp_v = {cur.busy, !cur.busy, cur.addr, cur.wdata, cur.in_en, cur.out_en,
               cur.rd_valid, cur.rd_data, cur.err, cur.count};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
      checks++;
      if (bus_register_input_en && bus_register_out_en) begin
        errors++;
        $display("FAIL enables_exclusive t=%0t actual=11 required=not both", $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] s, input logic [1:0] d,
                       input logic [15:0] imm);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = s; cmd_dst = d; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_src = 2'($urandom);
    cmd_dst = 2'($urandom); cmd_imm = 16'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 2'b00; cmd_dst = 2'b00;
    cmd_imm = 16'h0; cur = idle_e();
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(transfer_count), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b01, 2'd0, 2'd2, 16'hBEEF);
    chk("load_in_en", 32'(bus_register_input_en), 32'd1);
    chk("load_addr", 32'(register_addr), 32'd2);
    chk("load_data", 32'(bus_register_input), 32'hBEEF);
    chk("load_out_en", 32'(bus_register_out_en), 32'd0);
    @(negedge clk);
    chk("load_count", 32'(transfer_count), 32'd1);
    chk("load_done_in_en", 32'(bus_register_input_en), 32'd0);

    issue(2'b01, 2'd0, 2'd1, 16'h1234);
    @(negedge clk);
    issue(2'b00, 2'd1, 2'd3, 16'h0);
    chk("move_rd_out_en", 32'(bus_register_out_en), 32'd1);
    chk("move_rd_addr", 32'(register_addr), 32'd1);
    chk("move_rd_in_en", 32'(bus_register_input_en), 32'd0);
    @(negedge clk);
    chk("move_wr_in_en", 32'(bus_register_input_en), 32'd1);
    chk("move_wr_addr", 32'(register_addr), 32'd3);
    chk("move_wr_data", 32'(bus_register_input), 32'h1234);
    chk("move_wr_out_en", 32'(bus_register_out_en), 32'd0);
    @(negedge clk);
    chk("move_count", 32'(transfer_count), 32'd3);
    chk("move_bank3", 32'(bank[3]), 32'h1234);

    issue(2'b01, 2'd0, 2'd0, 16'hA5A5);
    @(negedge clk);
    issue(2'b10, 2'd0, 2'd0, 16'h0);
    chk("read_out_en", 32'(bus_register_out_en), 32'd1);
    chk("read_addr", 32'(register_addr), 32'd0);
    chk("read_in_en", 32'(bus_register_input_en), 32'd0);
    @(negedge clk);
    chk("read_rd_valid", 32'(rd_valid), 32'd1);
    chk("read_rd_data", 32'(rd_data), 32'hA5A5);
    chk("read_count", 32'(transfer_count), 32'd5);
    @(negedge clk);
    chk("read_valid_drop", 32'(rd_valid), 32'd0);
    chk("read_data_hold", 32'(rd_data), 32'hA5A5);

    issue(2'b11, 2'd1, 2'd2, 16'h5555);
    chk("rsvd_error", 32'(cmd_error), 32'd1);
    chk("rsvd_ready", 32'(cmd_ready), 32'd1);
    chk("rsvd_enables", 32'({bus_register_input_en, bus_register_out_en}), 32'd0);
    chk("rsvd_count", 32'(transfer_count), 32'd5);
    @(negedge clk);
    chk("rsvd_error_drop", 32'(cmd_error), 32'd0);

    issue(2'b00, 2'd2, 2'd1, 16'h0);
    chk("abort_out_en_before", 32'(bus_register_out_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_enables", 32'({bus_register_input_en, bus_register_out_en}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_count", 32'(transfer_count), 32'd0);
    chk("abort_no_write", 32'(bus_register_input_en), 32'd0);
    chk("abort_bank1", 32'(bank[1]), 32'h1234);

    cmd_valid = 1'b1; cmd_op = 2'b01;
    for (int i = 0; i < 511; i++) begin
      cmd_dst = 2'($urandom); cmd_imm = 16'($urandom); cmd_src = 2'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("wrap_count", 32'(transfer_count), 32'd0);

    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op = 2'($urandom); cmd_src = 2'($urandom);
      cmd_dst = 2'($urandom); cmd_imm = 16'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
